// File: rtl/data_bus_pkg.sv
// Shared DATA_BUS types: slave configuration word and master index used by the arbiter.
package data_bus_pkg;

  localparam int unsigned DATA_BUS_ARB_MAX_MASTERS = 8;

  typedef logic [2:0] arb_id_t;

  typedef struct packed {
    logic [1:0] mem_type;
    logic [1:0] priv;
  } config_type;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Single DATA_BUS channel: request phase from master, response and conf from slave.
interface data_bus_arbiter_if;
  import data_bus_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;
  config_type  conf;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, err, rdata, conf
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, err, rdata, conf
  );

endinterface

// File: rtl/data_bus_id_fifo.sv
// Flopped synchronous FIFO holding granted master IDs for in-order response routing.
module data_bus_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Extra pointer bit separates full from empty when indices match.
  assign wr_idx = (DEPTH == 1) ? '0 : wr_ptr_q[AW-1:0];
  assign rd_idx = (DEPTH == 1) ? '0 : rd_ptr_q[AW-1:0];
  assign full   = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign rdata  = mem_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_idx] <= wdata;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one DATA_BUS slave among N_MASTERS; responses routed
// back in order through an ID FIFO, grant held stable under slave back-pressure.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int unsigned N_MASTERS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned IDW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [N_MASTERS-1:0]                   m_req_i,
  input  logic [N_MASTERS*32-1:0]                m_addr_i,
  input  logic [N_MASTERS-1:0]                   m_we_i,
  input  logic [N_MASTERS*4-1:0]                 m_be_i,
  input  logic [N_MASTERS*32-1:0]                m_wdata_i,
  output logic [N_MASTERS-1:0]                   m_gnt_o,
  output logic [N_MASTERS-1:0]                   m_rvalid_o,
  output logic [N_MASTERS-1:0]                   m_err_o,
  output logic [N_MASTERS*32-1:0]                m_rdata_o,
  output logic [N_MASTERS*$bits(config_type)-1:0] m_conf_o,
  output logic                                   s_req_o,
  output logic [31:0]                            s_addr_o,
  output logic                                   s_we_o,
  output logic [3:0]                             s_be_o,
  output logic [31:0]                            s_wdata_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_rvalid_i,
  input  logic                                   s_err_i,
  input  logic [31:0]                            s_rdata_i,
  input  config_type                             s_conf_i,
  output logic                                   proto_err_o
);

  logic [IDW-1:0] rr_ptr_q, sel_q, sel, cand, idx, head;
  logic           lock_q, proto_err_q, found, hs, pop, fifo_full, fifo_empty;
  int             idx_int;

  // First requester at or after rr_ptr, wrapping; defaults to rr_ptr when idle.
  always_comb begin
    cand    = rr_ptr_q;
    found   = 1'b0;
    idx     = '0;
    idx_int = 0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      idx_int = int'(rr_ptr_q) + i;
      if (idx_int >= int'(N_MASTERS)) idx_int = idx_int - int'(N_MASTERS);
      idx = IDW'(idx_int);
      if (!found && m_req_i[idx]) begin
        cand  = idx;
        found = 1'b1;
      end
    end
  end

  assign sel = lock_q ? sel_q : cand;

  // Reset gating keeps the slave request and all grants low while rst_ni is asserted.
  assign s_req_o   = rst_ni & m_req_i[sel] & ~fifo_full & (lock_q | (|m_req_i));
  assign s_addr_o  = m_addr_i[32*int'(sel) +: 32];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = m_be_i[4*int'(sel) +: 4];
  assign s_wdata_o = m_wdata_i[32*int'(sel) +: 32];

  assign hs  = s_req_o & s_gnt_i;
  assign pop = s_rvalid_i & ~fifo_empty;

  always_comb begin
    m_gnt_o          = '0;
    m_rvalid_o       = '0;
    m_err_o          = '0;
    m_gnt_o[sel]     = hs;
    m_rvalid_o[head] = pop;
    m_err_o[head]    = pop & s_err_i;
  end

  assign m_rdata_o   = {N_MASTERS{s_rdata_i}};
  assign m_conf_o    = {N_MASTERS{s_conf_i}};
  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      lock_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (hs) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (sel == IDW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
      end else if (s_req_o) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (s_rvalid_i && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  data_bus_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (hs),
    .pop    (pop),
    .wdata  (sel),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with two masters and a 4-deep ID FIFO.
module tb_data_bus_arbiter;
  import data_bus_pkg::*;

  logic        clk, rst_ni;
  logic [1:0]  m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_be, m_conf;
  logic        proto_err;
  int          errors = 0;
  int          checks = 0;

  data_bus_arbiter_if bus ();

  data_bus_arbiter #(
    .N_MASTERS       (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .m_req_i     (m_req),
    .m_addr_i    (m_addr),
    .m_we_i      (m_we),
    .m_be_i      (m_be),
    .m_wdata_i   (m_wdata),
    .m_gnt_o     (m_gnt),
    .m_rvalid_o  (m_rvalid),
    .m_err_o     (m_err),
    .m_rdata_o   (m_rdata),
    .m_conf_o    (m_conf),
    .s_req_o     (bus.req),
    .s_addr_o    (bus.addr),
    .s_we_o      (bus.we),
    .s_be_o      (bus.be),
    .s_wdata_o   (bus.wdata),
    .s_gnt_i     (bus.gnt),
    .s_rvalid_i  (bus.rvalid),
    .s_err_i     (bus.err),
    .s_rdata_i   (bus.rdata),
    .s_conf_i    (bus.conf),
    .proto_err_o (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m_req = 2'b00; m_we = 2'b00; m_be = 8'hFF;
    m_addr = 64'h0; m_wdata = 64'h0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0;
    bus.rdata = 32'h0; bus.conf = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    m_req = 2'b11; bus.gnt = 1'b1; bus.rvalid = 1'b1;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_sreq got=%b exp=0", bus.req); end
    checks++; if (m_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", m_gnt); end
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", m_rvalid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto got=%b exp=0", proto_err); end
    @(negedge clk);
    idle_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    m_req = 2'b01; m_addr[31:0] = 32'h100; m_we = 2'b00; bus.gnt = 1'b1; bus.conf = 4'hA;
    #1;
    checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", m_gnt); end
    checks++; if (bus.addr !== 32'h100) begin errors++; $display("FAIL single_addr got=%h exp=100", bus.addr); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL single_we got=%b exp=0", bus.we); end
    checks++; if (m_conf !== 8'hAA) begin errors++; $display("FAIL conf_bcast got=%h exp=aa", m_conf); end
    @(negedge clk);
    m_req = 2'b00; bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
    #1;
    checks++; if (m_rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b exp=01", m_rvalid); end
    checks++; if (m_rdata !== 64'hDEADBEEF_DEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeefdeadbeef", m_rdata); end
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto got=%b exp=0", proto_err); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m_req = 2'b11; m_addr = {32'h20, 32'h10}; bus.gnt = 1'b1;
      exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (c % 2 == 0) ? 32'h10 : 32'h20;
      #1;
      checks++; if (m_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, m_gnt, exp_gnt); end
      checks++; if (bus.addr !== exp_addr) begin errors++; $display("FAIL rr_addr c=%0d got=%h exp=%h", c, bus.addr, exp_addr); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    m_req = 2'b01; m_addr = {32'h300, 32'h200}; bus.gnt = 1'b1;
    #1;
    checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL bp_pre_gnt got=%b exp=01", m_gnt); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.gnt = 1'b0;
      m_req = (c == 0) ? 2'b01 : 2'b11;
      #1;
      checks++; if (bus.addr !== 32'h200) begin errors++; $display("FAIL bp_addr c=%0d got=%h exp=200", c, bus.addr); end
      checks++; if (bus.req !== 1'b1 || m_gnt !== 2'b00) begin errors++; $display("FAIL bp_req c=%0d got=%b/%b exp=1/00", c, bus.req, m_gnt); end
    end
    @(negedge clk);
    bus.gnt = 1'b1;
    #1;
    checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL bp_release got=%b exp=01", m_gnt); end
    @(negedge clk);
    #1;
    checks++; if (m_gnt !== 2'b10 || bus.addr !== 32'h300) begin errors++; $display("FAIL bp_next got=%b/%h exp=10/300", m_gnt, bus.addr); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m_req = 2'b01; bus.gnt = 1'b1;
      #1;
      checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL full_fill c=%0d got=%b exp=01", c, m_gnt); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.req !== 1'b0 || m_gnt !== 2'b00) begin errors++; $display("FAIL full_block got=%b/%b exp=0/00", bus.req, m_gnt); end
    @(negedge clk);
    bus.rvalid = 1'b1;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL full_nocomb got=%b exp=0", bus.req); end
    checks++; if (m_rvalid !== 2'b01) begin errors++; $display("FAIL full_pop got=%b exp=01", m_rvalid); end
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    checks++; if (bus.req !== 1'b1 || m_gnt !== 2'b01) begin errors++; $display("FAIL full_resume got=%b/%b exp=1/01", bus.req, m_gnt); end
  endtask

  task automatic test_ordering();
    logic [5:0] rv_exp, er_exp, errs;
    rv_exp = 6'b10_01_10; er_exp = 6'b00_01_00; errs = 6'b00_01_00;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_req = rv_exp[4-2*c +: 2]; bus.gnt = 1'b1;
      #1;
      checks++; if (m_gnt !== rv_exp[4-2*c +: 2]) begin errors++; $display("FAIL ord_gnt c=%0d got=%b exp=%b", c, m_gnt, rv_exp[4-2*c +: 2]); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_req = 2'b00; bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.err = errs[4-2*c];
      #1;
      checks++; if (m_rvalid !== rv_exp[4-2*c +: 2]) begin errors++; $display("FAIL ord_rvalid c=%0d got=%b exp=%b", c, m_rvalid, rv_exp[4-2*c +: 2]); end
      checks++; if (m_err !== er_exp[4-2*c +: 2]) begin errors++; $display("FAIL ord_err c=%0d got=%b exp=%b", c, m_err, er_exp[4-2*c +: 2]); end
    end
    @(negedge clk);
    bus.rvalid = 1'b0; bus.err = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ord_proto got=%b exp=0", proto_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    m_req = 2'b01; bus.gnt = 1'b1;
    #1;
    checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL b2b_first got=%b exp=01", m_gnt); end
    @(negedge clk);
    m_req = 2'b10; bus.rvalid = 1'b1;
    #1;
    checks++; if (m_gnt !== 2'b10 || m_rvalid !== 2'b01) begin errors++; $display("FAIL b2b_pushpop got=%b/%b exp=10/01", m_gnt, m_rvalid); end
    @(negedge clk);
    m_req = 2'b00; bus.gnt = 1'b0;
    #1;
    checks++; if (m_rvalid !== 2'b10) begin errors++; $display("FAIL b2b_second got=%b exp=10", m_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL b2b_empty got=%b exp=00", m_rvalid); end
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL b2b_proto got=%b exp=1", proto_err); end
  endtask

  task automatic test_proto_reset();
    do_reset();
    @(negedge clk);
    bus.rvalid = 1'b1;
    #1;
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL proto_norv got=%b exp=00", m_rvalid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.rvalid = 1'b0;
      #1;
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky c=%0d got=%b exp=1", c, proto_err); end
    end
    @(negedge clk);
    m_req = 2'b11; bus.gnt = 1'b1;
    #1;
    checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL burst_gnt0 got=%b exp=01", m_gnt); end
    @(negedge clk);
    #1;
    checks++; if (m_gnt !== 2'b10) begin errors++; $display("FAIL burst_gnt1 got=%b exp=10", m_gnt); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b0 || m_gnt !== 2'b00 || bus.req !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%b/%b/%b exp=0/00/0", proto_err, m_gnt, bus.req);
    end
    @(negedge clk);
    rst_ni = 1'b1; m_req = 2'b00; bus.gnt = 1'b0; bus.rvalid = 1'b1;
    #1;
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL flush_rvalid got=%b exp=00", m_rvalid); end
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL flush_proto got=%b exp=1", proto_err); end
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_ordering();
    test_back_to_back();
    test_proto_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares one DATA_BUS slave port (memory, peripheral crossbar leg) between N_MASTERS requesters, e.g. core data port and DMA read/write engines.
- Round-robin arbitration on the request phase. Grants are held stable across slave back-pressure.
- A FIFO of granted master IDs routes in-order rvalid/err/rdata responses back to the issuing master.
- Sits between the masters' DATA_BUS.Master modports and the target's DATA_BUS.Slave modport; conf from the target is broadcast to all masters.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- MAX_OUTSTANDING, 4, depth of the response-routing ID FIFO (power of two, >=1).
- IDW, $clog2(N_MASTERS) (min 1), width of the master index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  N_MASTERS  per-master req
- m_addr_i  in  N_MASTERS*32  per-master addr, master k at [32k+:32]
- m_we_i  in  N_MASTERS  per-master we
- m_be_i  in  N_MASTERS*4  per-master be
- m_wdata_i  in  N_MASTERS*32  per-master wdata
- m_gnt_o  out  N_MASTERS  per-master gnt
- m_rvalid_o  out  N_MASTERS  per-master rvalid
- m_err_o  out  N_MASTERS  per-master err (qualified by rvalid)
- m_rdata_o  out  N_MASTERS*32  per-master rdata
- m_conf_o  out  N_MASTERS*$bits(config_type)  conf broadcast
- s_req_o, s_addr_o[32], s_we_o, s_be_o[4], s_wdata_o[32]  out  request to shared slave
- s_gnt_i, s_rvalid_i, s_err_i, s_rdata_i[32], s_conf_i(config_type)  in  slave response
- proto_err_o  out  1  sticky: rvalid received with empty ID FIFO

Behaviour:
- Reset values: rr_ptr=0, lock=0, sel_q=0, FIFO empty, proto_err_o=0. All gnt/rvalid/err outputs are 0 during reset. s_req_o=0.
- Arbitration:
  - Candidate = first requesting master at or after rr_ptr, wrapping modulo N_MASTERS.
  - sel = lock ? sel_q : candidate.
  - s_req_o = m_req_i[sel] & ~fifo_full & (lock | any m_req_i).
- Request mux: s_addr/we/be/wdata = master[sel] fields, combinational and zero-latency.
- Grant: m_gnt_o[sel] = s_gnt_i & s_req_o; all other m_gnt_o bits are 0.
- Handshake (s_req_o & s_gnt_i):
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod N_MASTERS.
  - lock <= 0.
- Back-pressure (s_req_o & ~s_gnt_i): lock <= 1, sel_q <= sel. The selection cannot change until that request is granted, so the slave sees stable req/addr.
- FIFO full:
  - s_req_o is forced to 0 and no new request is presented.
  - lock is not set while full.
  - No comb path from s_rvalid_i to s_req_o; a pop in cycle t frees space from cycle t+1.
- Response routing:
  - s_rvalid_i with FIFO non-empty: m_rvalid_o[head]=1, m_err_o[head]=s_err_i, and pop.
  - rdata is broadcast to all m_rdata_o slices. Only the head master's rvalid is asserted.
  - Response latency through the block is 0 cycles.
- Simultaneous push and pop (grant and rvalid in the same cycle): both occur and count is unchanged. Legal when not full.
- Same-cycle request/response: a response in the handshake cycle is not allowed by the bus protocol; if it occurs it is treated as belonging to the existing head, or as a protocol error if the FIFO is empty.
- Protocol error: s_rvalid_i with FIFO empty sets proto_err_o (sticky until reset) and asserts no m_rvalid_o.
- Wrap: FIFO pointers are IDW-independent, log2(MAX_OUTSTANDING)+1 bits, and wrap naturally. rr_ptr wraps N_MASTERS-1 -> 0 (explicit compare for non-power-of-two N).
- Reset mid-operation: the FIFO is flushed and the lock cleared. Outstanding responses arriving after reset flag proto_err_o.
- A master dropping req while locked is illegal. The arbiter keeps driving sel_q's current inputs and does not re-arbitrate.
- m_conf_o: every slice = s_conf_i.

Decomposition:
- data_bus_pkg: add DATA_BUS_ARB_MAX_MASTERS=8 and a typedef for master index (logic [2:0] arb_id_t). config_type stays as defined there.
- Sub-module data_bus_id_fifo: synchronous FIFO with flopped storage.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Simultaneous push/pop is allowed when full=0.
- The arbiter top holds the rr pointer, lock register and muxes.

Test Plan:
- Single master: m0 req addr=0x100 we=0, s_gnt=1 same cycle -> m_gnt_o=01, s_addr=0x100; s_rvalid one cycle later with rdata=0xDEADBEEF -> m_rvalid_o=01, m_rdata_o[0]=0xDEADBEEF.
- Round-robin: m0 and m1 request continuously, s_gnt=1 always -> grants alternate 01,10,01,10, starting with m0 after reset.
- Back-pressure lock: m0 requests with s_gnt=0 for 3 cycles while m1 raises req in cycle 1 -> s_addr stays m0's for all 3 cycles; m0 is granted in cycle 4, then m1 in cycle 5.
- FIFO full: MAX_OUTSTANDING=4, 4 grants with no rvalid -> s_req_o=0 in cycle 5. rvalid in cycle 6 -> s_req_o=1 again in cycle 7.
- Response ordering and err: grants m1, m0, m1, then rvalids with err=0,1,0 -> m_rvalid_o=10,01,10 and m_err_o[0]=1 only on the second response.
- Protocol error and reset: s_rvalid_i with FIFO empty -> proto_err_o=1 and stays 1. Asserting rst_ni=0 mid-burst -> proto_err_o=0, FIFO empty, gnt=0 asynchronously.
